uart_rx_calc: RTL and testbench

//  UART receiver, the upstream stage of the calculator frame: deserialises

---
 rtl/calc_pkg.sv | 29 ++
 rtl/baud_tick_gen.sv | 45 ++++
 rtl/uart_rx_calc.sv | 213 +++++++++++++++++++++
 tb/tb_uart_rx_calc.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator UART frame: receiver FSM states,
// ASCII codes the calculator core understands, and the default line rate.
package calc_pkg;

    localparam int DEF_CLK_FREQ = 100_000_000;
    localparam int DEF_BAUD     = 9600;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BRK   = 3'd4
    } rx_state_e;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_STAR  = 8'h2A;
    localparam logic [7:0] ASCII_EQ    = 8'h3D;
    localparam logic [7:0] ASCII_CR    = 8'h0D;

    // Three-tap majority vote used for mid-bit sampling.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running divide-by-DIV tick generator with a synchronous restart so
// that the tick phase can be realigned to an incoming start-bit edge.
module baud_tick_gen #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Next count and next tick; the tick flop is high exactly while the count sits on its last value.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (restart) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        tick_d = (!restart) && (cnt_d == LAST);
    end

    // Counter and tick registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_rx_calc.sv
// 8N1 UART receiver feeding the calculator core: 2-flop synchroniser,
// 16x oversampling, 3-tap mid-bit vote, framing-error detection with a
// break-wait state so a held-low line reports only one error.
module uart_rx_calc
    import calc_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int BAUD     = DEF_BAUD,
    parameter int N        = 8,
    parameter int OVS      = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rxd_pin,
    output logic [N-1:0] rx_data,
    output logic         rx_valid,
    output logic         frame_err,
    output logic         busy,
    output logic [3:0]   led
);

    localparam int         DIV      = CLK_FREQ / (BAUD * OVS);
    localparam int         BW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [3:0] OVS_LAST = 4'(OVS - 1);
    localparam logic [3:0] VOTE_A   = 4'(OVS / 2 - 1);
    localparam logic [3:0] VOTE_B   = 4'(OVS / 2);
    localparam logic [3:0] VOTE_C   = 4'(OVS / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

    rx_state_e     state_q, state_d;
    logic          meta_q, rxs_q;
    logic [3:0]    ovs_q, ovs_d;
    logic [BW-1:0] bit_idx_q, bit_idx_d;
    logic [N-1:0]  shift_q, shift_d;
    logic          tap_a_q, tap_a_d, tap_b_q, tap_b_d;
    logic [N-1:0]  rx_data_q, rx_data_d;
    logic [3:0]    led_q, led_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          busy_q, busy_d;

    logic          rxs_s, tick_s, restart_s, vote_s, mid_s, bit_end_s;
    logic [3:0]    ovs_next_s;

    baud_tick_gen #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (restart_s),
        .tick    (tick_s)
    );

    assign rxs_s      = rxs_q;
    assign vote_s     = maj3(tap_a_q, tap_b_q, rxs_s);
    assign mid_s      = tick_s && (ovs_q == VOTE_C);
    assign bit_end_s  = tick_s && (ovs_q == OVS_LAST);
    assign ovs_next_s = (ovs_q == OVS_LAST) ? 4'd0 : (ovs_q + 4'd1);

    // Next-state logic: bit timing, vote capture, shifting and output pulses.
    always_comb begin
        state_d     = state_q;
        ovs_d       = ovs_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        tap_a_d     = tap_a_q;
        tap_b_d     = tap_b_q;
        rx_data_d   = rx_data_q;
        led_d       = led_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        restart_s   = 1'b0;

        // First two vote taps are captured in every state; only the mid tick acts on them.
        if (tick_s && (ovs_q == VOTE_A)) begin
            tap_a_d = rxs_s;
        end else begin
            tap_a_d = tap_a_q;
        end
        if (tick_s && (ovs_q == VOTE_B)) begin
            tap_b_d = rxs_s;
        end else begin
            tap_b_d = tap_b_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rxs_s) begin
                    state_d   = ST_START;
                    restart_s = 1'b1;
                    ovs_d     = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    ovs_d = ovs_next_s;
                end else begin
                    ovs_d = ovs_q;
                end
                if (mid_s && vote_s) begin
                    state_d = ST_IDLE;       // start bit did not hold: glitch
                end else if (bit_end_s) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    ovs_d = ovs_next_s;
                end else begin
                    ovs_d = ovs_q;
                end
                if (mid_s) begin
                    shift_d = {vote_s, shift_q[N-1:1]};
                end else begin
                    shift_d = shift_q;
                end
                if (bit_end_s) begin
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    ovs_d = ovs_next_s;
                end else begin
                    ovs_d = ovs_q;
                end
                if (mid_s) begin
                    if (vote_s) begin
                        // Leave half a stop bit early so a back-to-back start edge is caught.
                        rx_data_d  = shift_q;
                        led_d      = shift_q[3:0];
                        rx_valid_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BRK;
                        ovs_d       = 4'd0;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_BRK: begin
                // Require one full bit time of continuous high before rearming.
                if (!rxs_s) begin
                    ovs_d = 4'd0;
                end else if (bit_end_s) begin
                    ovs_d   = 4'd0;
                    state_d = ST_IDLE;
                end else if (tick_s) begin
                    ovs_d = ovs_q + 4'd1;
                end else begin
                    ovs_d = ovs_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ovs_d   = 4'd0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, synchroniser and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            meta_q      <= 1'b1;
            rxs_q       <= 1'b1;
            ovs_q       <= 4'd0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            tap_a_q     <= 1'b1;
            tap_b_q     <= 1'b1;
            rx_data_q   <= '0;
            led_q       <= 4'd0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            meta_q      <= rxd_pin;
            rxs_q       <= meta_q;
            ovs_q       <= ovs_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            tap_a_q     <= tap_a_d;
            tap_b_q     <= tap_b_d;
            rx_data_q   <= rx_data_d;
            led_q       <= led_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign led       = led_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_calc.sv
// Directed bench for uart_rx_calc at 1 Mbaud (DIV=6, 96 clk per bit).
module tb_uart_rx_calc;
    import calc_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd_pin;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;
    logic [3:0] led;

    int checks = 0;
    int fails  = 0;

    // Written only by the monitor below.
    logic [7:0] got_q[$];
    int ferr_cnt = 0;
    int both_cnt = 0;

    int b0;
    int f0;

    always #5 clk = ~clk;

    uart_rx_calc #(.BAUD(1_000_000)) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd_pin   (rxd_pin),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy),
        .led       (led)
    );

    // Record every cycle of rx_valid / frame_err, so a multi-cycle pulse shows up as extra entries.
    always @(negedge clk) begin
        if (rx_valid) got_q.push_back(rx_data);
        if (frame_err) ferr_cnt++;
        if (rx_valid && frame_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rxd_pin = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Send one 8N1 character; rst_at >= 0 pulses reset at that cycle and the sender abandons the character.
    task automatic send(input logic [7:0] b, input logic stop, input int bt, input int rst_at);
        logic [9:0] frame;
        int cyc;
        logic aborted;
        frame   = {stop, b, 1'b0};
        cyc     = 0;
        aborted = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rxd_pin = aborted ? 1'b1 : frame[i];
            for (int j = 0; j < bt; j++) begin
                @(posedge clk);
                #1;
                reset = (cyc == rst_at);
                if (rst_at >= 0 && cyc == rst_at + 1) begin
                    aborted = 1'b1;
                    rxd_pin = 1'b1;
                    @(negedge clk);
                    check("midreset_rx_data", 32'(rx_data), 32'h0);
                    check("midreset_busy", 32'(busy), 32'h0);
                    check("midreset_state", 32'(dut.state_q), 32'(ST_IDLE));
                end
                cyc++;
            end
        end
    endtask

    initial begin
        rxd_pin = 1'b1;
        reset   = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_rx_data", 32'(rx_data), 32'h0);
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_led", 32'(led), 32'h0);
        idle(10);

        // 1: single character '5'
        b0 = got_q.size(); f0 = ferr_cnt;
        send(8'h35, 1'b1, 96, -1);
        idle(60);
        @(negedge clk);
        check("t1_pulses", 32'(got_q.size() - b0), 32'd1);
        if (got_q.size() > b0) check("t1_data", 32'(got_q[b0]), 32'h35);
        check("t1_rx_data", 32'(rx_data), 32'h35);
        check("t1_led", 32'(led), 32'h5);
        check("t1_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("t1_busy", 32'(busy), 32'h0);

        // 2: 20-cycle glitch
        b0 = got_q.size(); f0 = ferr_cnt;
        rxd_pin = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        rxd_pin = 1'b1;
        @(negedge clk);
        check("t2_busy_high", 32'(busy), 32'h1);
        idle(75);
        @(negedge clk);
        check("t2_busy_dropped", 32'(busy), 32'h0);
        check("t2_state", 32'(dut.state_q), 32'(ST_IDLE));
        check("t2_pulses", 32'(got_q.size() - b0), 32'd0);
        check("t2_ferr", 32'(ferr_cnt - f0), 32'd0);
        idle(20);

        // 3: framing error then a good byte
        b0 = got_q.size(); f0 = ferr_cnt;
        send(8'h41, 1'b0, 96, -1);
        idle(200);
        @(negedge clk);
        check("t3_ferr_once", 32'(ferr_cnt - f0), 32'd1);
        check("t3_no_valid", 32'(got_q.size() - b0), 32'd0);
        check("t3_rx_data_held", 32'(rx_data), 32'h35);
        send(8'h33, 1'b1, 96, -1);
        idle(60);
        @(negedge clk);
        check("t3_good_pulses", 32'(got_q.size() - b0), 32'd1);
        check("t3_good_data", 32'(rx_data), 32'h33);
        check("t3_led", 32'(led), 32'h3);

        // 4: "2+3=" back to back
        b0 = got_q.size(); f0 = ferr_cnt;
        send(8'h32, 1'b1, 96, -1);
        send(8'h2B, 1'b1, 96, -1);
        send(8'h33, 1'b1, 96, -1);
        send(8'h3D, 1'b1, 96, -1);
        idle(60);
        @(negedge clk);
        check("t4_pulses", 32'(got_q.size() - b0), 32'd4);
        if (got_q.size() >= b0 + 4) begin
            check("t4_c0", 32'(got_q[b0]),     32'h32);
            check("t4_c1", 32'(got_q[b0 + 1]), 32'h2B);
            check("t4_c2", 32'(got_q[b0 + 2]), 32'h33);
            check("t4_c3", 32'(got_q[b0 + 3]), 32'h3D);
        end
        check("t4_ferr", 32'(ferr_cnt - f0), 32'd0);

        // 5: reset during data bit 4 of 0x7F, then 0x0D
        b0 = got_q.size(); f0 = ferr_cnt;
        send(8'h7F, 1'b1, 96, 528);
        idle(100);
        @(negedge clk);
        check("t5_no_pulse", 32'(got_q.size() - b0), 32'd0);
        check("t5_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("t5_rx_data_zero", 32'(rx_data), 32'h0);
        send(8'h0D, 1'b1, 96, -1);
        idle(60);
        @(negedge clk);
        check("t5_cr_pulses", 32'(got_q.size() - b0), 32'd1);
        check("t5_cr_data", 32'(rx_data), 32'h0D);

        // 6: sender clock off by about +-2%
        b0 = got_q.size();
        send(8'hA5, 1'b1, 94, -1);
        idle(60);
        @(negedge clk);
        check("t6_fast_pulses", 32'(got_q.size() - b0), 32'd1);
        check("t6_fast_data", 32'(rx_data), 32'hA5);
        send(8'h3C, 1'b1, 96, -1);
        idle(40);
        b0 = got_q.size();
        send(8'hA5, 1'b1, 98, -1);
        idle(60);
        @(negedge clk);
        check("t6_slow_pulses", 32'(got_q.size() - b0), 32'd1);
        check("t6_slow_data", 32'(rx_data), 32'hA5);

        check("valid_and_ferr_overlap", 32'(both_cnt), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
